// File: rtl/shift_arbiter_if.sv
// Request/grant and actuator bundle for the gearshift arbiter.
// master = requester/driver side, slave = arbiter side.
interface shift_arbiter_if;
    logic       drv_up_req;
    logic       drv_dn_req;
    logic       ecu_up_req;
    logic       ecu_dn_req;
    logic       drv_ack;
    logic       ecu_ack;
    logic       drv_nack;
    logic       ecu_nack;
    logic       up_sol;
    logic       dn_sol;
    logic       ign_cut;
    logic [2:0] gear;
    logic       busy;

    modport master (
        output drv_up_req, drv_dn_req, ecu_up_req, ecu_dn_req,
        input  drv_ack, ecu_ack, drv_nack, ecu_nack,
        input  up_sol, dn_sol, ign_cut, gear, busy
    );

    modport slave (
        input  drv_up_req, drv_dn_req, ecu_up_req, ecu_dn_req,
        output drv_ack, ecu_ack, drv_nack, ecu_nack,
        output up_sol, dn_sol, ign_cut, gear, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Gearshift arbiter: driver/ECU arbitration, gear tracking, cut/pulse/holdoff.
// SHIFT_IGN_CUT_EN enables the ignition-cut lead phase before upshifts.
module shift_arbiter #(
    parameter int unsigned NORMAL_CYCLES  = 5000000,
    parameter int unsigned NEUTRAL_CYCLES = 2500000,
    parameter int unsigned CUT_CYCLES     = 250000,
    parameter int unsigned HOLDOFF_CYCLES = 10000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic            clk,
    input  logic            rst,
    shift_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTUATE = 2'd1,
        HOLDOFF = 2'd2
`ifdef SHIFT_IGN_CUT_EN
        ,CUT    = 2'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(NORMAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] NEUT_LAST = CNT_W'(NEUTRAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CUT_LAST  = CNT_W'(CUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, last;
    logic [2:0]       gear, gear_n;
    logic             up_sol, up_sol_n;
    logic             dn_sol, dn_sol_n;
    logic             ign_cut, ign_cut_n;
    logic             neutral, neutral_n;
    logic             drv_ack, drv_ack_n;
    logic             drv_nack, drv_nack_n;
    logic             ecu_ack, ecu_ack_n;
    logic             ecu_nack, ecu_nack_n;

    logic             drv_up_q, drv_dn_q;
    logic             ecu_up_q, ecu_dn_q;
    logic             drv_arm, ecu_arm;

    logic             drv_sel, ecu_sel;
    logic             sel_up, sel_dn;
    logic             bad, nshift;

    // Arbitration and validation work from the registered request copies.
    always_comb begin
        drv_sel = drv_arm & (drv_up_q | drv_dn_q);
        ecu_sel = ~drv_sel & ecu_arm & (ecu_up_q | ecu_dn_q);
        sel_up  = drv_sel ? drv_up_q : ecu_up_q;
        sel_dn  = drv_sel ? drv_dn_q : ecu_dn_q;
        bad     = (sel_up & sel_dn)
                | (sel_up & (gear == 3'd6))
                | (sel_dn & (gear == 3'd0));
        nshift  = (sel_up & (gear == 3'd0))
                | (sel_dn & (gear == 3'd1));
    end

    always_comb begin
        last = CUT_LAST;
        unique case (state)
            ACTUATE: last = neutral ? NEUT_LAST : NORM_LAST;
            HOLDOFF: last = HOLD_LAST;
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        gear_n     = gear;
        up_sol_n   = up_sol;
        dn_sol_n   = dn_sol;
        ign_cut_n  = ign_cut;
        neutral_n  = neutral;
        drv_ack_n  = 1'b0;
        drv_nack_n = 1'b0;
        ecu_ack_n  = 1'b0;
        ecu_nack_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (drv_sel | ecu_sel) begin
                    if (bad) begin
                        drv_nack_n = drv_sel;
                        ecu_nack_n = ecu_sel;
                    end else begin
                        drv_ack_n = drv_sel;
                        ecu_ack_n = ecu_sel;
                        gear_n    = sel_up ? gear + 3'd1 : gear - 3'd1;
                        neutral_n = nshift;
                        state_n   = ACTUATE;
                        // Neutral<->first always uses the dn solenoid.
                        up_sol_n  = sel_up & ~nshift;
                        dn_sol_n  = ~(sel_up & ~nshift);
`ifdef SHIFT_IGN_CUT_EN
                        if (sel_up & ~nshift) begin
                            state_n   = CUT;
                            up_sol_n  = 1'b0;
                            dn_sol_n  = 1'b0;
                            ign_cut_n = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef SHIFT_IGN_CUT_EN
            CUT: begin
                if (cnt == last) begin
                    state_n  = ACTUATE;
                    cnt_n    = '0;
                    up_sol_n = 1'b1;
                end
            end
`endif
            ACTUATE: begin
                if (cnt == last) begin
                    state_n   = HOLDOFF;
                    cnt_n     = '0;
                    up_sol_n  = 1'b0;
                    dn_sol_n  = 1'b0;
                    ign_cut_n = 1'b0;
                end
            end
            HOLDOFF: begin
                if (cnt == last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                up_sol_n  = 1'b0;
                dn_sol_n  = 1'b0;
                ign_cut_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gear     <= 3'd0;
            up_sol   <= 1'b0;
            dn_sol   <= 1'b0;
            ign_cut  <= 1'b0;
            neutral  <= 1'b0;
            drv_ack  <= 1'b0;
            drv_nack <= 1'b0;
            ecu_ack  <= 1'b0;
            ecu_nack <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gear     <= gear_n;
            up_sol   <= up_sol_n;
            dn_sol   <= dn_sol_n;
            ign_cut  <= ign_cut_n;
            neutral  <= neutral_n;
            drv_ack  <= drv_ack_n;
            drv_nack <= drv_nack_n;
            ecu_ack  <= ecu_ack_n;
            ecu_nack <= ecu_nack_n;
        end
    end

    // Arming looks at the live request lines so a level held through
    // reset never arms itself off the cleared request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_up_q <= 1'b0;
            drv_dn_q <= 1'b0;
            ecu_up_q <= 1'b0;
            ecu_dn_q <= 1'b0;
            drv_arm  <= 1'b0;
            ecu_arm  <= 1'b0;
        end else begin
            drv_up_q <= bus.drv_up_req;
            drv_dn_q <= bus.drv_dn_req;
            ecu_up_q <= bus.ecu_up_req;
            ecu_dn_q <= bus.ecu_dn_req;
            if (drv_ack_n | drv_nack_n)
                drv_arm <= 1'b0;
            else if (~bus.drv_up_req & ~bus.drv_dn_req)
                drv_arm <= 1'b1;
            if (ecu_ack_n | ecu_nack_n)
                ecu_arm <= 1'b0;
            else if (~bus.ecu_up_req & ~bus.ecu_dn_req)
                ecu_arm <= 1'b1;
        end
    end

    assign bus.drv_ack  = drv_ack;
    assign bus.drv_nack = drv_nack;
    assign bus.ecu_ack  = ecu_ack;
    assign bus.ecu_nack = ecu_nack;
    assign bus.up_sol   = up_sol;
    assign bus.dn_sol   = dn_sol;
    assign bus.ign_cut  = ign_cut;
    assign bus.gear     = gear;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with short phase lengths.
// Expectations follow SHIFT_IGN_CUT_EN when it is defined.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_arbiter_if sif ();

    shift_arbiter #(
        .NORMAL_CYCLES  (8),
        .NEUTRAL_CYCLES (4),
        .CUT_CYCLES     (2),
        .HOLDOFF_CYCLES (5),
        .CNT_W          (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_IGN_CUT_EN
    localparam int CU  = 2;
    localparam int IGL = 10;
    localparam int IGF = 1;
`else
    localparam int CU  = 0;
    localparam int IGL = 0;
    localparam int IGF = -1;
`endif
    localparam int UPF = 1 + CU;
    localparam int UPB = 13 + CU;
    localparam int WIN = 24;

    typedef struct {
        logic du, dd, eu, ed;
        int   hold;
        int   dack, dnack, eack, enack;
        int   gear;
        int   up_len, up_first;
        int   dn_len, dn_first;
        int   ign_len, ign_first;
        int   busy_len;
    } vec_t;

    vec_t tbl [20];

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic du, input logic dd,
                           input logic eu, input logic ed);
        sif.drv_up_req = du;
        sif.drv_dn_req = dd;
        sif.ecu_up_req = eu;
        sif.ecu_dn_req = ed;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sif.busy !== 1'b0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic apply(input int id, input vec_t v);
        int dack, dnack, eack, enack;
        int upl, upf, dnl, dnf, igl, igf, bl;
        string s;
        dack = 0; dnack = 0; eack = 0; enack = 0;
        upl = 0; upf = -1; dnl = 0; dnf = -1;
        igl = 0; igf = -1; bl = 0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        set_req(v.du, v.dd, v.eu, v.ed);
        for (int i = 0; i < WIN; i++) begin
            @(posedge clk);
            #1;
            if (i == v.hold - 1) set_req(1'b0, 1'b0, 1'b0, 1'b0);
            dack  += int'(sif.drv_ack);
            dnack += int'(sif.drv_nack);
            eack  += int'(sif.ecu_ack);
            enack += int'(sif.ecu_nack);
            bl    += int'(sif.busy);
            if (sif.up_sol === 1'b1) begin
                upl++;
                if (upf < 0) upf = i;
            end
            if (sif.dn_sol === 1'b1) begin
                dnl++;
                if (dnf < 0) dnf = i;
            end
            if (sif.ign_cut === 1'b1) begin
                igl++;
                if (igf < 0) igf = i;
            end
        end
        n_vec++;
        s = $sformatf("v%0d", id);
        chk({s, ".drv_ack"},  dack,  v.dack);
        chk({s, ".drv_nack"}, dnack, v.dnack);
        chk({s, ".ecu_ack"},  eack,  v.eack);
        chk({s, ".ecu_nack"}, enack, v.enack);
        chk({s, ".gear"},     int'(sif.gear), v.gear);
        chk({s, ".up_len"},   upl, v.up_len);
        chk({s, ".up_first"}, upf, v.up_first);
        chk({s, ".dn_len"},   dnl, v.dn_len);
        chk({s, ".dn_first"}, dnf, v.dn_first);
        chk({s, ".ign_len"},  igl, v.ign_len);
        chk({s, ".ign_first"},igf, v.ign_first);
        chk({s, ".busy_len"}, bl,  v.busy_len);
    endtask

    task automatic seq_contend();
        int dfirst, efirst, dcnt, ecnt, nk, g1;
        dfirst = -1; efirst = -1; dcnt = 0; ecnt = 0; nk = 0; g1 = -1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        set_req(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) sif.drv_dn_req = 1'b0;
            if (i == 1) g1 = int'(sif.gear);
            if (sif.drv_ack === 1'b1) begin
                dcnt++;
                if (dfirst < 0) dfirst = i;
            end
            if (sif.ecu_ack === 1'b1) begin
                ecnt++;
                if (efirst < 0) efirst = i;
                sif.ecu_up_req = 1'b0;
            end
            nk += int'(sif.drv_nack) + int'(sif.ecu_nack);
        end
        n_vec++;
        chk("contend.drv_first", dfirst, 1);
        chk("contend.drv_cnt",   dcnt,   1);
        chk("contend.gear_mid",  g1,     2);
        chk("contend.ecu_first", efirst, 15);
        chk("contend.ecu_cnt",   ecnt,   1);
        chk("contend.nacks",     nk,     0);
        chk("contend.gear_end",  int'(sif.gear), 3);
    endtask

    task automatic seq_reset();
        int seen, acks;
        seen = 0; acks = 0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (sif.up_sol === 1'b1) seen = 1;
        end
        chk("rst.up_sol_seen", seen, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("rst.up_sol",  int'(sif.up_sol),  0);
        chk("rst.dn_sol",  int'(sif.dn_sol),  0);
        chk("rst.ign_cut", int'(sif.ign_cut), 0);
        chk("rst.busy",    int'(sif.busy),    0);
        chk("rst.gear",    int'(sif.gear),    0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            acks += int'(sif.drv_ack) + int'(sif.drv_nack) + int'(sif.busy);
        end
        chk("rst.held_no_grant", acks, 0);
        chk("rst.held_gear",     int'(sif.gear), 0);
        sif.drv_up_req = 1'b0;
    endtask

    initial begin : main
        //             du dd eu ed hold dack dn eack en gear upL upF dnL dnF igL igF busy
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 3, 1,0,0,0, 1, 0,-1, 4, 1,  0, -1,   9};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 1, 0,0,1,0, 2, 8,UPF,0,-1, IGL,IGF, UPB};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 1, 1,0,0,0, 3, 8,UPF,0,-1, IGL,IGF, UPB};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0, 1, 0,0,1,0, 4, 8,UPF,0,-1, IGL,IGF, UPB};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 1, 1,0,0,0, 5, 8,UPF,0,-1, IGL,IGF, UPB};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 1, 1,0,0,0, 6, 8,UPF,0,-1, IGL,IGF, UPB};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 1, 0,1,0,0, 6, 0,-1, 0,-1,  0, -1,   0};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 1, 0,0,0,1, 6, 0,-1, 0,-1,  0, -1,   0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 1, 1,0,0,0, 5, 0,-1, 8, 1,  0, -1,  13};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 1, 0,1,0,0, 5, 0,-1, 0,-1,  0, -1,   0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1, 1, 0,0,1,0, 4, 0,-1, 8, 1,  0, -1,  13};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0, 1, 1,0,0,0, 3, 0,-1, 8, 1,  0, -1,  13};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 1, 1,0,0,0, 2, 0,-1, 8, 1,  0, -1,  13};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1, 1, 0,0,1,0, 1, 0,-1, 8, 1,  0, -1,  13};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b0, 1, 1,0,0,0, 0, 0,-1, 4, 1,  0, -1,   9};
        tbl[15] = '{1'b0,1'b1,1'b0,1'b0, 1, 0,1,0,0, 0, 0,-1, 0,-1,  0, -1,   0};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0, 1, 0,1,0,0, 0, 0,-1, 0,-1,  0, -1,   0};
        tbl[17] = '{1'b0,1'b0,1'b1,1'b1, 1, 0,0,0,1, 0, 0,-1, 0,-1,  0, -1,   0};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b0, 1, 1,0,0,0, 1, 0,-1, 4, 1,  0, -1,   9};
        tbl[19] = '{1'b0,1'b0,1'b1,1'b0, 1, 0,0,1,0, 2, 8,UPF,0,-1, IGL,IGF, UPB};

        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        chk("reset.gear",     int'(sif.gear),     0);
        chk("reset.busy",     int'(sif.busy),     0);
        chk("reset.up_sol",   int'(sif.up_sol),   0);
        chk("reset.dn_sol",   int'(sif.dn_sol),   0);
        chk("reset.ign_cut",  int'(sif.ign_cut),  0);
        chk("reset.acks",     int'(sif.drv_ack) + int'(sif.ecu_ack), 0);
        chk("reset.nacks",    int'(sif.drv_nack) + int'(sif.ecu_nack), 0);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) apply(i, tbl[i]);
        seq_contend();
        for (int i = 12; i < 20; i++) apply(i, tbl[i]);
        seq_reset();
        apply(100, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing and arbitration controller for the gearshift actuators. It accepts up/down shift requests from two requesters, the driver paddles and the ECU auto-shift. It grants one request at a time, tracks the current gear (neutral to sixth), and drives a timed sequence: optional ignition cut, then a solenoid pulse, then a hold-off lockout. It sits between the debounced paddle inputs or ECU command interface and the up/down solenoid drivers.

## Interface
- NORMAL_CYCLES, 5000000, solenoid pulse length for gear-to-gear shifts (100 ms at 50 MHz)
- NEUTRAL_CYCLES, 2500000, dn_sol pulse length for neutral↔first shifts
- CUT_CYCLES, 250000, ignition-cut lead time before an upshift pulse
- HOLDOFF_CYCLES, 10000000, lockout after each pulse
- CNT_W, 32, width of the single shared phase counter
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- drv_up_req, drv_dn_req  in  1  driver shift requests (level)
- ecu_up_req, ecu_dn_req  in  1  ECU shift requests (level)
- drv_ack, ecu_ack  out  1  one-cycle pulse: request granted
- drv_nack, ecu_nack  out  1  one-cycle pulse: request rejected
- up_sol, dn_sol  out  1  solenoid drives
- ign_cut  out  1  ignition cut request to the ECU
- gear  out  3  commanded gear: 0 is neutral, 1–6 are gears
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE → CUT → ACTUATE → HOLDOFF → IDLE. CUT is used for upshifts only.
- Arming:
  - Each requester has an armed flag, cleared by reset and on that requester's ack or nack.
  - The flag sets on any cycle where both of that requester's req lines are low.
  - Unarmed requesters are ignored, so a held paddle never auto-repeats.
- Arbitration: requests are sampled only in IDLE. An armed driver has strict priority over an armed ECU. A losing ECU request gets no response and is re-evaluated in the next IDLE.
- Validation of the selected requester:
  - nack if up and dn are both high.
  - nack if up is requested at gear 6.
  - nack if dn is requested at gear 0.
  - On nack the state stays IDLE.
- Grant (valid request):
  - Pulse ack and update gear (±1) in the same registered cycle.
  - An upshift enters CUT; a downshift enters ACTUATE directly.
- Pulse selection:
  - Upshift from gear 1 or higher: up_sol for NORMAL_CYCLES.
  - Downshift from gear 2 or higher: dn_sol for NORMAL_CYCLES.
  - 0→1 and 1→0: dn_sol for NEUTRAL_CYCLES. These skip CUT regardless of direction.
- ign_cut is high throughout CUT and ACTUATE of an upshift, and low otherwise.
- Counter: loaded to 0 on state entry, increments each cycle, and the state exits when count == length−1. Every length parameter must be ≥1.
- Reset values: all outputs 0, gear 0, state IDLE, counter 0, both armed flags 0.
- Reset mid-sequence deasserts the solenoids and ign_cut immediately (asynchronously). gear returns to 0.

## Timing
- A request is seen in IDLE at edge t. ack/nack and the new gear are valid after edge t+1.
- Upshift: ign_cut rises at t+1, up_sol rises at t+1+CUT_CYCLES, and up_sol stays high exactly NORMAL_CYCLES.
- Downshift: dn_sol rises at t+1.
- HOLDOFF starts the cycle the solenoid falls and lasts HOLDOFF_CYCLES. The earliest next grant is registered on the first IDLE cycle's following edge.
- Driver and ECU requests asserted in the same IDLE cycle: only drv_ack fires. ecu_ack can fire at the earliest one IDLE cycle after the driver's sequence completes.
- Outputs are registered, with no combinational paths from inputs to outputs.

## Configuration
- SHIFT_IGN_CUT_EN defined: CUT state is present and ign_cut behaves as specified above.
- SHIFT_IGN_CUT_EN undefined:
  - CUT state is removed, and upshifts go IDLE→ACTUATE like downshifts.
  - up_sol rises at t+1.
  - ign_cut is tied to 0.
  - CUT_CYCLES is ignored.

## Test plan
All scenarios use NORMAL=8, NEUTRAL=4, CUT=2, HOLDOFF=5, with SHIFT_IGN_CUT_EN defined unless noted.
- Gear 0, drv_up_req held 3 cycles → drv_ack once, gear=1, and dn_sol high 4 cycles starting at t+1. ign_cut stays 0, and there is no second shift while the request is held.
- Gear 1, ecu_up_req pulse → ecu_ack, gear=2, and ign_cut high from t+1. up_sol is high for 8 cycles starting at t+3, ign_cut falls with up_sol, and busy stays high for 2+8+5 cycles.
- Gear 3, drv_dn_req and ecu_up_req in the same cycle → only drv_ack fires and gear=2. ecu_ack fires after HOLDOFF, then gear=3.
- Gear 6, drv_up_req → drv_nack, gear stays 6, and no solenoid activity. Gear 0, drv_up_req and drv_dn_req together → drv_nack.
- Gear 2, upshift, rst asserted during ACTUATE → up_sol, ign_cut, and busy are 0 with no clock edge, and gear=0. A request held through reset is not granted until it is released and reasserted.
- SHIFT_IGN_CUT_EN undefined, gear 2, upshift → up_sol rises at t+1 and ign_cut stays 0 throughout.
